// File: rtl/stm_sequencer.sv
// rtl/stm_sequencer.sv - multi-segment STM index/segment sequencer; define STM_SEQUENCER_DEBUG_EN for DEBUG_LOOP/DEBUG_STATE ports
module stm_sequencer #(
  parameter int NUM_SEGMENT = 2,
  parameter int IDX_WIDTH   = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int REP_WIDTH   = 16,
  localparam int SEG_W      = $clog2(NUM_SEGMENT)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             UPDATE,
  input  logic                             SET,
  input  logic [SEG_W-1:0]                 REQ_SEGMENT,
  input  logic [1:0]                       TRANSITION_MODE,
  input  logic [REP_WIDTH-1:0]             REP,
  input  logic [NUM_SEGMENT*IDX_WIDTH-1:0] CYCLE,
  input  logic [NUM_SEGMENT*DIV_WIDTH-1:0] FREQ_DIV,
  input  logic                             EXT_TRIG,
  output logic [SEG_W-1:0]                 SEGMENT,
  output logic [IDX_WIDTH-1:0]             IDX,
  output logic                             START,
  output logic                             STOP,
  output logic                             PENDING
`ifdef STM_SEQUENCER_DEBUG_EN
  ,
  output logic [REP_WIDTH-1:0]             DEBUG_LOOP,
  output logic [1:0]                       DEBUG_STATE
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;

  localparam logic [1:0] MODE_IMM  = 2'd0;
  localparam logic [1:0] MODE_WRAP = 2'd1;
  localparam logic [1:0] MODE_TRIG = 2'd2;

  state_t                 state_q, state_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [REP_WIDTH-1:0]   loop_cnt_q, loop_cnt_d;
  logic [REP_WIDTH-1:0]   rep_q, rep_d;
  logic                   start_q, start_d;
  logic                   stop_q, stop_d;
  logic                   pend_q, pend_d;
  logic                   armed_q, armed_d;
  logic                   trig_prev_q, trig_prev_d;
  logic [SEG_W-1:0]       req_seg_q, req_seg_d;
  logic [1:0]             req_mode_q, req_mode_d;
  logic [REP_WIDTH-1:0]   req_rep_q, req_rep_d;

  logic [IDX_WIDTH-1:0]   cycle_arr [NUM_SEGMENT];
  logic [DIV_WIDTH-1:0]   div_arr   [NUM_SEGMENT];
  logic [IDX_WIDTH-1:0]   cur_cycle;
  logic [DIV_WIDTH-1:0]   cur_div;
  logic [DIV_WIDTH-1:0]   div_last;
  logic [1:0]             eff_mode;
  logic                   trig_rise;
  logic                   req_ok;
  logic                   step_due;
  logic                   at_end;
  logic                   rep_inf;
  logic                   apply_now;

  for (genvar s = 0; s < NUM_SEGMENT; s++) begin : g_unpack
    assign cycle_arr[s] = CYCLE[s*IDX_WIDTH +: IDX_WIDTH];
    assign div_arr[s]   = FREQ_DIV[s*DIV_WIDTH +: DIV_WIDTH];
  end

  // Active-segment configuration and the step/wrap/apply decisions for this cycle
  always_comb begin
    cur_cycle = cycle_arr[seg_q];
    cur_div   = div_arr[seg_q];
    // A divider of zero behaves like one: step on every UPDATE
    div_last  = (cur_div == '0) ? '0 : cur_div - 1'b1;
    eff_mode  = (req_mode_q == 2'd3) ? MODE_IMM : req_mode_q;
    trig_rise = EXT_TRIG & ~trig_prev_q;
    req_ok    = (32'(REQ_SEGMENT) < NUM_SEGMENT);
    step_due  = (state_q == ST_RUN) && (div_cnt_q >= div_last);
    // Compare with >= so a CYCLE shrunk below the current index wraps on the next step
    at_end    = (idx_q >= cur_cycle);
    rep_inf   = &rep_q;
    apply_now = 1'b0;
    case (state_q)
      ST_IDLE:    apply_now = pend_q;
      ST_STOPPED: apply_now = pend_q && ((eff_mode != MODE_TRIG) || armed_q || trig_rise);
      default: begin
        case (eff_mode)
          MODE_WRAP: apply_now = pend_q && step_due && at_end;
          MODE_TRIG: apply_now = pend_q && (armed_q || trig_rise);
          default:   apply_now = pend_q;
        endcase
      end
    endcase
  end

  // Next-state: UPDATE stepping or request application, then SET latching on top
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    idx_d       = idx_q;
    div_cnt_d   = div_cnt_q;
    loop_cnt_d  = loop_cnt_q;
    rep_d       = rep_q;
    start_d     = 1'b0;
    stop_d      = stop_q;
    pend_d      = pend_q;
    armed_d     = armed_q;
    trig_prev_d = EXT_TRIG;
    req_seg_d   = req_seg_q;
    req_mode_d  = req_mode_q;
    req_rep_d   = req_rep_q;

    if (pend_q && (eff_mode == MODE_TRIG) && trig_rise) begin
      armed_d = 1'b1;
    end

    if (UPDATE) begin
      start_d = (state_q != ST_IDLE) || apply_now;
      if (apply_now) begin
        state_d    = ST_RUN;
        seg_d      = req_seg_q;
        idx_d      = '0;
        div_cnt_d  = '0;
        loop_cnt_d = '0;
        rep_d      = req_rep_q;
        stop_d     = 1'b0;
        pend_d     = 1'b0;
        armed_d    = 1'b0;
      end else if (state_q == ST_RUN) begin
        if (!step_due) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (!at_end) begin
            idx_d = idx_q + 1'b1;
          end else begin
            loop_cnt_d = loop_cnt_q + 1'b1;
            // This wrap would make loop_cnt equal REP+1: hold the last index and stop
            if (!rep_inf && (loop_cnt_q == rep_q)) begin
              state_d = ST_STOPPED;
              stop_d  = 1'b1;
            end else begin
              idx_d = '0;
            end
          end
        end
      end
    end

    // A new request replaces any pending one and must see its own trigger edge
    if (SET && req_ok) begin
      req_seg_d  = REQ_SEGMENT;
      req_mode_d = TRANSITION_MODE;
      req_rep_d  = REP;
      pend_d     = 1'b1;
      armed_d    = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      seg_q       <= '0;
      idx_q       <= '0;
      div_cnt_q   <= '0;
      loop_cnt_q  <= '0;
      rep_q       <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      pend_q      <= 1'b0;
      armed_q     <= 1'b0;
      trig_prev_q <= 1'b0;
      req_seg_q   <= '0;
      req_mode_q  <= 2'd0;
      req_rep_q   <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      idx_q       <= idx_d;
      div_cnt_q   <= div_cnt_d;
      loop_cnt_q  <= loop_cnt_d;
      rep_q       <= rep_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      pend_q      <= pend_d;
      armed_q     <= armed_d;
      trig_prev_q <= trig_prev_d;
      req_seg_q   <= req_seg_d;
      req_mode_q  <= req_mode_d;
      req_rep_q   <= req_rep_d;
    end
  end

  assign SEGMENT = seg_q;
  assign IDX     = idx_q;
  assign START   = start_q;
  assign STOP    = stop_q;
  assign PENDING = pend_q;

`ifdef STM_SEQUENCER_DEBUG_EN
  assign DEBUG_LOOP  = loop_cnt_q;
  assign DEBUG_STATE = state_q;
`endif

endmodule
